// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file unit.
// Slot indices, selector type and the exchange sequencer states.
package regfile_pkg;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned SP_IDX   = 6;
  localparam int unsigned SB_IDX   = 7;
  localparam int unsigned SEG_BASE = 8;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MOVE  = 2'd2,
    STORE = 2'd3
  } xchg_state_t;
endpackage

// File: rtl/register_file_unit_sp_ctrl.sv
// Stack pointer register: explicit load, push/pop stepping and a sticky bounds fault.
// A faulting push or pop leaves the pointer untouched.
module sp_ctrl #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SP_STEP  = 1,
  parameter int unsigned SP_RESET = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_ld_val,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_fault_clr,
  input  logic [WIDTH-1:0] i_sb,
  output logic [WIDTH-1:0] o_sp,
  output logic             o_fault
);
  logic [WIDTH-1:0] r_sp;
  logic             r_fault;
  logic [WIDTH-1:0] w_sp_nxt;
  logic             w_fault_set;
  logic [WIDTH:0]   w_push_lim;
  logic [WIDTH:0]   w_pop_sum;

  // One extra bit so the limits cannot wrap.
  assign w_push_lim = {1'b0, i_sb} + (WIDTH+1)'(SP_STEP);
  assign w_pop_sum  = {1'b0, r_sp} + (WIDTH+1)'(SP_STEP);

  always_comb begin
    w_sp_nxt    = r_sp;
    w_fault_set = 1'b0;
    if (i_ld) begin
      w_sp_nxt = i_ld_val;
    end else if (i_push && !i_pop) begin
      if ({1'b0, r_sp} < w_push_lim) w_fault_set = 1'b1;
      else                           w_sp_nxt    = r_sp - WIDTH'(SP_STEP);
    end else if (i_pop && !i_push) begin
      if (w_pop_sum[WIDTH]) w_fault_set = 1'b1;
      else                  w_sp_nxt    = w_pop_sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sp    <= WIDTH'(SP_RESET);
      r_fault <= 1'b0;
    end else begin
      r_sp <= w_sp_nxt;
      if (w_fault_set)      r_fault <= 1'b1;
      else if (i_fault_clr) r_fault <= 1'b0;
    end
  end

  assign o_sp    = r_sp;
  assign o_fault = r_fault;
endmodule

// File: rtl/register_file_unit.sv
// Register file on a shared tri-state bus with stack, segment, memory-address and
// instruction registers, a sequenced exchange, a debug read port and contention flag.
module register_file_unit
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NREGS    = 16,
  parameter int unsigned SEL_W    = regfile_pkg::SEL_W,
  parameter int unsigned SP_IDX   = regfile_pkg::SP_IDX,
  parameter int unsigned SB_IDX   = regfile_pkg::SB_IDX,
  parameter int unsigned SEG_BASE = regfile_pkg::SEG_BASE,
  parameter int unsigned NSEG     = 4,
  parameter int unsigned SP_STEP  = 1,
  parameter int unsigned SP_RESET = 0,
  parameter int unsigned IMM_W    = 10
) (
  input  logic             clk,
  input  logic             r,
  inout  tri logic [WIDTH-1:0] bus,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic             rd_oe,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic             wr_en,
  input  logic             sp_push,
  input  logic             sp_pop,
  input  logic             fault_clr,
  output logic             stack_fault,
  input  logic [2:0]       seg_sel,
  output logic [WIDTH-1:0] seg_o,
  input  logic             mem_we,
  output logic [WIDTH-1:0] mem_o,
  input  logic             instr_we,
  input  logic             instr_oe,
  output logic [WIDTH-1:0] instr_o,
  input  logic             xchg_req,
  input  logic [SEL_W-1:0] xchg_a,
  input  logic [SEL_W-1:0] xchg_b,
  output logic             busy,
  output logic             done,
  input  logic [SEL_W-1:0] dbg_sel,
  output logic [WIDTH-1:0] dbg_o,
  output logic             bus_conflict
);
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_tmp, r_mem, r_instr;
  logic [SEL_W-1:0] r_xa, r_xb;
  xchg_state_t      r_state, w_next;
  logic             r_busy, r_done;

  logic [WIDTH-1:0] w_view [NREGS];
  logic [WIDTH-1:0] w_sp;
  logic             w_done_d, w_cap, w_idle, w_xchg_ok;
  logic             w_wr_en;
  logic [SEL_W-1:0] w_wr_sel;
  logic [WIDTH-1:0] w_wr_val;
  logic             w_rd_drv, w_lo_en;
  logic [WIDTH-1:0] w_rd_val;
  logic [IMM_W-1:0] w_lo_val;
  logic [SEL_W-1:0] w_seg_idx;
  logic             w_seg_ok;

  // Slot 0 and out-of-range selectors mean "no register".
  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    return (s != '0) && (32'(s) < NREGS);
  endfunction

  // Architectural view of every slot; SP lives in the stack controller.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (i == 0)           w_view[i] = '0;
      else if (i == SP_IDX) w_view[i] = w_sp;
      else                  w_view[i] = r_regs[i];
    end
  end

  assign w_idle    = (r_state == IDLE);
  assign w_xchg_ok = sel_ok(xchg_a) && sel_ok(xchg_b) && (xchg_a != xchg_b);

  always_comb begin
    w_next   = r_state;
    w_done_d = 1'b0;
    w_cap    = 1'b0;
    w_wr_en  = 1'b0;
    w_wr_sel = '0;
    w_wr_val = '0;
    case (r_state)
      IDLE: begin
        if (xchg_req) begin
          if (w_xchg_ok) begin
            w_next = LOAD;
            w_cap  = 1'b1;
          end else begin
            w_done_d = 1'b1;
          end
        end
        if (wr_en && sel_ok(wr_sel)) begin
          w_wr_en  = 1'b1;
          w_wr_sel = wr_sel;
          w_wr_val = bus;
        end
      end
      LOAD: w_next = MOVE;
      MOVE: begin
        w_next   = STORE;
        w_done_d = 1'b1;
        w_wr_en  = 1'b1;
        w_wr_sel = r_xa;
        w_wr_val = w_view[r_xb];
      end
      STORE: begin
        w_next   = IDLE;
        w_wr_en  = 1'b1;
        w_wr_sel = r_xb;
        w_wr_val = r_tmp;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_done  <= w_done_d;
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_tmp   <= '0;
      r_xa    <= '0;
      r_xb    <= '0;
      r_mem   <= '0;
      r_instr <= '0;
    end else begin
      if (w_cap) begin
        r_xa <= xchg_a;
        r_xb <= xchg_b;
      end
      if (r_state == LOAD) r_tmp <= w_view[r_xa];
      if (w_wr_en && (w_wr_sel != SEL_W'(SP_IDX))) r_regs[w_wr_sel] <= w_wr_val;
      if (mem_we)   r_mem   <= bus;
      if (instr_we) r_instr <= bus;
    end
  end

  sp_ctrl #(
    .WIDTH   (WIDTH),
    .SP_STEP (SP_STEP),
    .SP_RESET(SP_RESET)
  ) u_sp_ctrl (
    .i_clk      (clk),
    .i_rst      (r),
    .i_ld       (w_wr_en && (w_wr_sel == SEL_W'(SP_IDX))),
    .i_ld_val   (w_wr_val),
    .i_push     (sp_push && w_idle),
    .i_pop      (sp_pop && w_idle),
    .i_fault_clr(fault_clr),
    .i_sb       (r_regs[SB_IDX]),
    .o_sp       (w_sp),
    .o_fault    (stack_fault)
  );

  // Immediate drive owns the low bits; a simultaneous register read is dropped.
  assign w_rd_drv = rd_oe && !instr_oe && sel_ok(rd_sel);
  assign w_rd_val = w_view[rd_sel];
  assign w_lo_en  = instr_oe || w_rd_drv;
  assign w_lo_val = instr_oe ? r_instr[IMM_W-1:0] : w_rd_val[IMM_W-1:0];
  assign bus[IMM_W-1:0]     = w_lo_en  ? w_lo_val : 'z;
  assign bus[WIDTH-1:IMM_W] = w_rd_drv ? w_rd_val[WIDTH-1:IMM_W] : 'z;

  assign bus_conflict = rd_oe && instr_oe;

  assign w_seg_ok  = (seg_sel != 3'd0) && (32'(seg_sel) <= NSEG);
  assign w_seg_idx = SEL_W'(SEG_BASE + 32'(seg_sel) - 32'd1);
  assign seg_o     = w_seg_ok ? w_view[w_seg_idx] : '0;

  assign dbg_o   = sel_ok(dbg_sel) ? w_view[dbg_sel] : '0;
  assign mem_o   = r_mem;
  assign instr_o = r_instr;
  assign busy    = r_busy;
  assign done    = r_done;
endmodule
